rv32_fetch_stage: RTL and testbench

- Stage 1 of the core: owns the PC, issues word requests to instruction memory, and buffers returned words in a small FIFO.
- Presents {instr, pc} to the decode stage over a valid/ready handshake.
- Handles control-flow redirects from the execute stage: flushes the FIFO and discards in-flight responses.
- Memory responses have no backpressure, so the block issues a request only when a FIFO slot is guaranteed for its response (credit scheme).

---
 rtl/rv32_fetch_stage.sv | 121 ++++++++++++
 tb/tb_rv32_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32_fetch_stage.sv
// rv32_fetch_stage -- instruction fetch, stage 1 of the core.
//
// Owns the PC, issues word requests to instruction memory and buffers the
// returned words in a small FIFO that feeds decode. Memory responses cannot
// be stalled. A request is therefore issued only when a buffer slot is
// already reserved for its response: outstanding + occupancy < FIFO_DEPTH.
// A redirect flushes the buffer. Responses that are still in flight are
// counted in r_disc and dropped when they arrive.
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request (word address)
//   imem_rsp_valid/data             in-order response, no backpressure
//   redirect_valid/pc               flush and restart fetch at redirect_pc
//   dec_valid/ready/instr/pc        buffer head to decode (NOP / 0 when empty)
module rv32_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0]  DEPTH_C = CW1'(FIFO_DEPTH);
    localparam logic [31:0]  NOP     = 32'h0000_0013;

    logic [31:0]   r_pc;
    logic          r_run;      // holds request valid low until the first edge after reset
    logic [CW-1:0] r_out;      // requests accepted, response not yet seen
    logic [CW-1:0] r_occ;      // instruction buffer occupancy
    logic [CW-1:0] r_disc;     // in-flight responses still to drop after a redirect

    logic [31:0]   r_ib_instr [FIFO_DEPTH];
    logic [31:0]   r_ib_pc    [FIFO_DEPTH];
    logic [31:0]   r_tag      [FIFO_DEPTH];
    logic [AW-1:0] r_ib_head, r_ib_tail, r_tag_head, r_tag_tail;

    logic [CW:0]   w_sum;
    logic          w_accept, w_rsp, w_drop, w_push, w_pop;
    logic [CW-1:0] w_out_next;

    assign w_sum          = {1'b0, r_out} + {1'b0, r_occ};
    assign imem_req_valid = r_run & (w_sum < DEPTH_C);
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid & imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp          = imem_rsp_valid & (r_out != '0);
    assign w_drop         = w_rsp & (r_disc != '0);
    assign w_push         = w_rsp & ~w_drop;
    assign dec_valid      = (r_occ != '0);
    assign w_pop          = dec_valid & dec_ready;
    assign w_out_next     = r_out + CW'(w_accept) - CW'(w_rsp);

    assign dec_instr      = dec_valid ? r_ib_instr[r_ib_head] : NOP;
    assign dec_pc         = dec_valid ? r_ib_pc[r_ib_head]    : 32'h0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc       <= RESET_PC;
            r_run      <= 1'b0;
            r_out      <= '0;
            r_occ      <= '0;
            r_disc     <= '0;
            r_ib_head  <= '0;
            r_ib_tail  <= '0;
            r_tag_head <= '0;
            r_tag_tail <= '0;
        end else begin
            r_run <= 1'b1;
            r_out <= w_out_next;
            // The tag FIFO is never flushed: discarded responses pop their own tags.
            if (w_accept) r_tag_tail <= r_tag_tail + AW'(1);
            if (w_rsp)    r_tag_head <= r_tag_head + AW'(1);
            if (redirect_valid) begin
                // Includes a request accepted in this same cycle.
                r_pc      <= {redirect_pc[31:2], 2'b00};
                r_disc    <= w_out_next;
                r_occ     <= '0;
                r_ib_head <= '0;
                r_ib_tail <= '0;
            end else begin
                if (w_accept) r_pc      <= r_pc + 32'd4;
                if (w_drop)   r_disc    <= r_disc - CW'(1);
                if (w_push)   r_ib_tail <= r_ib_tail + AW'(1);
                if (w_pop)    r_ib_head <= r_ib_head + AW'(1);
                r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (w_accept) r_tag[r_tag_tail] <= r_pc;
        if (w_push) begin
            r_ib_instr[r_ib_tail] <= imem_rsp_data;
            r_ib_pc[r_ib_tail]    <= r_tag[r_tag_head];
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!imem_rsp_valid || (r_out != '0));
            assert (w_sum <= DEPTH_C);
        end
    end

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// Bench for rv32_fetch_stage. Two instances share all inputs: u_dut
// (RESET_PC=0) and u_wrap (RESET_PC=FFFF_FFF8). Their control timing is
// identical, so u_wrap sees the same traffic at addresses offset until the
// first redirect. The reference model tracks requests as a queue of pending
// transactions (address, due cycle, killed flag) and the decode buffer as a
// queue of PCs.
module tb_rv32_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] WRAP  = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_ready = 1'b1;

    logic        imem_req_valid, dec_valid;
    logic [31:0] imem_req_addr, dec_instr, dec_pc;
    logic        w_req_valid, w_dec_valid;
    logic [31:0] w_req_addr, w_dec_instr, w_dec_pc;

    always #5 clk = ~clk;

    rv32_fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .resetn(resetn),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc)
    );

    rv32_fetch_stage #(.RESET_PC(WRAP), .FIFO_DEPTH(DEPTH)) u_wrap (
        .clk(clk), .resetn(resetn),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(w_dec_valid), .dec_ready(dec_ready),
        .dec_instr(w_dec_instr), .dec_pc(w_dec_pc)
    );

    int          nvec = 0, nerr = 0, cyc = 0;
    logic [31:0] pa[$];        // pending request addresses (oldest first)
    int          pd[$];        // cycle each response is due
    bit          pk[$];        // response killed by a redirect
    logic [31:0] mf[$];        // PCs expected in the decode buffer
    logic [31:0] exp_fetch, off;
    bit          m_run, rnd_lat;
    int          lat, nacc, first_acc, first_dv;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, NOP);
        chk("rst_dec_pc",    dec_pc, 32'h0);
        chk("rst_addr",      imem_req_addr, 32'h0);
        chk("rst_w_req_valid", 32'(w_req_valid), 32'd0);
        chk("rst_w_dec_valid", 32'(w_dec_valid), 32'd0);
        chk("rst_w_addr",    w_req_addr, WRAP);
        pa.delete(); pd.delete(); pk.delete(); mf.delete();
        exp_fetch = 32'h0; off = WRAP; m_run = 1'b0;
        first_acc = -1; first_dv = -1; nacc = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        bit rsp, mv, mdv, acc, fire, k;
        logic [31:0] a;
        int L;
        rsp = 1'b0;
        if (pd.size() > 0) rsp = (pd[0] <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? f(pa[0]) : $urandom;
        #1;
        mv  = m_run && (pa.size() + mf.size() < DEPTH);
        mdv = (mf.size() != 0);
        chk("req_valid",   32'(imem_req_valid), 32'(mv));
        chk("req_addr",    imem_req_addr, exp_fetch);
        chk("dec_valid",   32'(dec_valid), 32'(mdv));
        chk("dec_pc",      dec_pc, mdv ? mf[0] : 32'h0);
        chk("dec_instr",   dec_instr, mdv ? f(mf[0]) : NOP);
        chk("w_req_valid", 32'(w_req_valid), 32'(mv));
        chk("w_req_addr",  w_req_addr, exp_fetch + off);
        chk("w_dec_valid", 32'(w_dec_valid), 32'(mdv));
        chk("w_dec_pc",    w_dec_pc, mdv ? mf[0] + off : 32'h0);
        chk("w_dec_instr", w_dec_instr, mdv ? f(mf[0]) : NOP);
        if (imem_req_valid && imem_req_ready) nacc++;
        if (first_dv < 0 && dec_valid) first_dv = cyc;
        acc  = mv && imem_req_ready;
        fire = mdv && dec_ready;
        if (first_acc < 0 && acc) first_acc = cyc;
        k = 1'b0; a = 32'h0;
        if (rsp) begin
            a = pa.pop_front(); k = pk.pop_front(); void'(pd.pop_front());
        end
        if (fire) void'(mf.pop_front());
        if (rsp && !k) mf.push_back(a);
        if (acc) begin
            L = rnd_lat ? $urandom_range(1, 3) : lat;
            pa.push_back(exp_fetch); pd.push_back(cyc + L); pk.push_back(1'b0);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect_valid) begin
            mf.delete();
            foreach (pk[i]) pk[i] = 1'b1;
            exp_fetch = {redirect_pc[31:2], 2'b00};
            off = 32'h0;
        end
        @(posedge clk);
        cyc++;
        if (resetn) m_run = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        bit found;
        lat = 1; rnd_lat = 1'b0;
        @(negedge clk);

        // Streaming with a 1-cycle memory; wrap instance crosses 2^32.
        do_reset();
        for (int i = 0; i < 30; i++) tick();
        chk("first_latency", 32'(first_dv - first_acc), 32'd2);

        // Decode stalled: exactly DEPTH requests, then drain.
        do_reset();
        dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("stall_accepts", 32'(nacc), 32'(DEPTH));
        chk("stall_head_pc", dec_pc, 32'h0);
        dec_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Two requests in flight on a 3-cycle memory, then redirect to 0x103.
        do_reset();
        lat = 3;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pa.size() == 2 && pa[0] == 32'h10 && pa[1] == 32'h14 && !pk[0] && !pk[1])
                found = 1'b1;
            else
                tick();
        end
        chk("c_two_inflight", 32'(found), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        chk("c_next_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 20 && !dec_valid; i++) tick();
        chk("c_dec_valid", 32'(dec_valid), 32'd1);
        chk("c_dec_pc", dec_pc, 32'h100);
        for (int i = 0; i < 10; i++) tick();

        // Redirect coinciding with an accept and a response.
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pd.size() > 0 && pd[0] <= cyc && m_run && (pa.size() + mf.size() < DEPTH))
                found = 1'b1;
            else
                tick();
        end
        chk("d_coincide", 32'(found), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        chk("d_fifo_empty", 32'(dec_valid), 32'd0);
        for (int i = 0; i < 10; i++) tick();

        // Random ready/latency/redirects with a reset mid-stream.
        rnd_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            imem_req_ready = ($urandom_range(0, 3) != 0);
            dec_ready      = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
